// File: rtl/hsdaoh_pkg.sv
// Shared definitions for the hsdaoh sample source: mode encodings, word
// geometry and the test-pattern LFSR.
package hsdaoh_pkg;

    localparam int SAMPLE_W = 10;
    localparam int WORD_W   = 20;

    localparam logic [WORD_W-1:0] LFSR_SEED = 20'h00001;
    localparam int LFSR_TAP_A = 19;
    localparam int LFSR_TAP_B = 16;

    typedef enum logic [1:0] {
        MODE_ADC  = 2'd0,
        MODE_CNT  = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_IDLE = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Fibonacci step for x^20+x^17+1: shift left, feed back q[19]^q[16].
    function automatic logic [WORD_W-1:0] lfsrNext(input logic [WORD_W-1:0] q);
        return {q[WORD_W-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/hsdaoh_boxcar_decim.sv
// One channel of the power-of-two boxcar decimator. The phase counter lives in
// the parent so both channels close their sums on the same strobe.
module hsdaoh_boxcar_decim
    import hsdaoh_pkg::*;
#(
    parameter int MAX_DEC_LOG2 = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                valid_i,
    input  logic                lastPhase_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic [2:0]          decLog2_i,
    output logic [SAMPLE_W-1:0] avg_o
);

    localparam int ACC_W = SAMPLE_W + MAX_DEC_LOG2;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    // The closing sample is folded in combinationally so d=0 is a pure pass-through.
    assign sum   = acc_q + ACC_W'(sample_i);
    assign avg_o = SAMPLE_W'(sum >> decLog2_i);

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (valid_i) begin
            acc_d = lastPhase_i ? '0 : sum;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/hsdaoh_sample_source.sv
// ADC-domain producer for the HDMI output core: packs paired ADC samples or
// test patterns into 20-bit words on the async FIFO write side.
module hsdaoh_sample_source
    import hsdaoh_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int MAX_DEC_LOG2 = 4
) (
    input  logic              clk_data,
    input  logic              rstn,
    input  logic [9:0]        adc_a,
    input  logic [9:0]        adc_b,
    input  logic              adc_valid,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [2:0]        dec_log2,
    input  logic              overflow_clr,
    input  logic              fifo_full,
    input  logic              fifo_afull,
    output logic              fifo_write_en,
    output logic [19:0]       fifo_data,
    output logic              overflow,
    output logic [CNT_W-1:0]  dropped_cnt,
    output logic              active
);

    localparam int         PH_W    = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;
    localparam logic [2:0] DEC_MAX = 3'(MAX_DEC_LOG2);

    logic                enable_q;
    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [2:0]          dec_q, dec_d;

    logic [SAMPLE_W-1:0] s1A_q, s1B_q;
    logic                s1Valid_q;

    logic [PH_W-1:0]     phase_q, phase_d;
    logic [PH_W-1:0]     phaseMax;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                wordValid_q, wordValid_d;
    logic [WORD_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]   lfsr_q, lfsr_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    dropped_q, dropped_d;

    logic                enRise;
    logic                runAdc;
    logic                patRun;
    logic                adcStrobe;
    logic                lastPhase;
    logic                wordReady;
    logic                adcWrite;
    logic                patWrite;
    logic                drop;
    logic [SAMPLE_W-1:0] avgA, avgB;

    assign enRise = enable & ~enable_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dec_d   = dec_q;
        if (enRise) begin
            mode_d = mode_e'(mode);
            dec_d  = (dec_log2 > DEC_MAX) ? DEC_MAX : dec_log2;
        end
        case (state_q)
            ST_IDLE: if (enRise && (mode_e'(mode) != MODE_IDLE)) state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Gating with the live enable drops any partial sum the cycle enable falls.
    assign runAdc = (state_q == ST_RUN) && enable && (mode_q == MODE_ADC);
    assign patRun = (state_q == ST_RUN) && enable &&
                    ((mode_q == MODE_CNT) || (mode_q == MODE_LFSR));

    always_comb begin
        phaseMax = '0;
        for (int i = 0; i < PH_W; i++) begin
            phaseMax[i] = (i < int'(dec_q));
        end
    end

    assign adcStrobe = runAdc & s1Valid_q;
    assign lastPhase = (phase_q == phaseMax);
    assign wordReady = adcStrobe & lastPhase;

    always_comb begin
        phase_d = phase_q;
        if (!runAdc) begin
            phase_d = '0;
        end else if (adcStrobe) begin
            phase_d = lastPhase ? '0 : phase_q + PH_W'(1);
        end
    end

    hsdaoh_boxcar_decim #(.MAX_DEC_LOG2(MAX_DEC_LOG2)) u_decimA (
        .clk_i       (clk_data),
        .rst_ni      (rstn),
        .clear_i     (~runAdc),
        .valid_i     (adcStrobe),
        .lastPhase_i (lastPhase),
        .sample_i    (s1A_q),
        .decLog2_i   (dec_q),
        .avg_o       (avgA)
    );

    hsdaoh_boxcar_decim #(.MAX_DEC_LOG2(MAX_DEC_LOG2)) u_decimB (
        .clk_i       (clk_data),
        .rst_ni      (rstn),
        .clear_i     (~runAdc),
        .valid_i     (adcStrobe),
        .lastPhase_i (lastPhase),
        .sample_i    (s1B_q),
        .decLog2_i   (dec_q),
        .avg_o       (avgB)
    );

    // ADC words are gated against fifo_full in the cycle they are presented.
    assign adcWrite = wordValid_q & ~fifo_full;
    assign drop     = wordValid_q & fifo_full;
    assign patWrite = patRun & ~fifo_afull & ~fifo_full;

    always_comb begin
        wordValid_d = wordReady;
        word_d      = wordReady ? {avgA, avgB} : word_q;

        cnt_d  = cnt_q;
        lfsr_d = lfsr_q;
        if (enRise) begin
            cnt_d  = '0;
            lfsr_d = LFSR_SEED;
        end else if (patWrite) begin
            if (mode_q == MODE_CNT)  cnt_d  = cnt_q + WORD_W'(1);
            if (mode_q == MODE_LFSR) lfsr_d = lfsrNext(lfsr_q);
        end

        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (overflow_clr) begin
                dropped_d = CNT_W'(1);
            end else if (dropped_q != '1) begin
                dropped_d = dropped_q + CNT_W'(1);
            end
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
            dropped_d  = '0;
        end
    end

    always_ff @(posedge clk_data or negedge rstn) begin
        if (!rstn) begin
            enable_q    <= 1'b0;
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ADC;
            dec_q       <= '0;
            s1A_q       <= '0;
            s1B_q       <= '0;
            s1Valid_q   <= 1'b0;
            phase_q     <= '0;
            word_q      <= '0;
            wordValid_q <= 1'b0;
            cnt_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            overflow_q  <= 1'b0;
            dropped_q   <= '0;
        end else begin
            enable_q    <= enable;
            state_q     <= state_d;
            mode_q      <= mode_d;
            dec_q       <= dec_d;
            s1A_q       <= adc_a;
            s1B_q       <= adc_b;
            s1Valid_q   <= adc_valid;
            phase_q     <= phase_d;
            word_q      <= word_d;
            wordValid_q <= wordValid_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            overflow_q  <= overflow_d;
            dropped_q   <= dropped_d;
        end
    end

    always_comb begin
        case (mode_q)
            MODE_CNT:  fifo_data = cnt_q;
            MODE_LFSR: fifo_data = lfsr_q;
            default:   fifo_data = word_q;
        endcase
    end

    assign fifo_write_en = adcWrite | patWrite;
    assign overflow      = overflow_q;
    assign dropped_cnt   = dropped_q;
    assign active        = (state_q == ST_RUN);

endmodule

// File: tb/tb_hsdaoh_sample_source.sv
// Scoreboard bench for hsdaoh_sample_source: stimulus pushes expected words,
// a negedge monitor pops and compares them whenever fifo_write_en is seen.
module tb_hsdaoh_sample_source;

    logic        clk_data = 1'b0;
    logic        rstn;
    logic [9:0]  adc_a, adc_b;
    logic        adc_valid;
    logic        enable;
    logic [1:0]  mode;
    logic [2:0]  dec_log2;
    logic        overflow_clr;
    logic        fifo_full;
    logic        fifo_afull;
    logic        fifo_write_en;
    logic [19:0] fifo_data;
    logic        overflow;
    logic [15:0] dropped_cnt;
    logic        active;

    typedef struct {
        logic [19:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cycCnt = 0;
    bit          patChk = 1'b0;
    logic [19:0] lfsrExp [1:21];
    logic [19:0] cntModel;
    logic [9:0]  decA [0:3];
    logic [9:0]  decB [0:3];

    hsdaoh_sample_source #(.CNT_W(16), .MAX_DEC_LOG2(4)) dut (
        .clk_data      (clk_data),
        .rstn          (rstn),
        .adc_a         (adc_a),
        .adc_b         (adc_b),
        .adc_valid     (adc_valid),
        .enable        (enable),
        .mode          (mode),
        .dec_log2      (dec_log2),
        .overflow_clr  (overflow_clr),
        .fifo_full     (fifo_full),
        .fifo_afull    (fifo_afull),
        .fifo_write_en (fifo_write_en),
        .fifo_data     (fifo_data),
        .overflow      (overflow),
        .dropped_cnt   (dropped_cnt),
        .active        (active)
    );

    always #5 clk_data = ~clk_data;

    always @(posedge clk_data) cycCnt <= cycCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycCnt);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_data);
        #1;
    endtask

    task automatic expectWord(input logic [19:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [9:0] a, input logic [9:0] b, input logic v);
        adc_a     = a;
        adc_b     = b;
        adc_valid = v;
        stepCycle();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "/write_en"}, 32'(fifo_write_en), 32'd0);
        checkOutput({tag, "/data"}, 32'(fifo_data), 32'd0);
        checkOutput({tag, "/overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, "/dropped"}, 32'(dropped_cnt), 32'd0);
        checkOutput({tag, "/active"}, 32'(active), 32'd0);
    endtask

    // Leaves the bench in the first cycle the DUT is in RUN with the new config.
    task automatic restart(input logic [1:0] m, input logic [2:0] d);
        enable = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("activeLowAfterDisable", 32'(active), 32'd0);
        mode     = m;
        dec_log2 = d;
        enable   = 1'b1;
        stepCycle();
    endtask

    always @(negedge clk_data) begin
        exp_t e;
        if (fifo_full) checkOutput("noWriteWhileFull", 32'(fifo_write_en), 32'd0);
        if (patChk && fifo_afull) checkOutput("noWriteWhileAfull", 32'(fifo_write_en), 32'd0);
        if (fifo_write_en) begin
            checkOutput("writeExpected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("wordData", 32'(fifo_data), 32'(e.data));
                if (e.cyc >= 0) checkOutput("wordCycle", 32'(cycCnt), 32'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 1; k <= 17; k++) lfsrExp[k] = 20'(1) << (k - 1);
        lfsrExp[18] = 20'h20001;
        lfsrExp[19] = 20'h40002;
        lfsrExp[20] = 20'h80004;
        lfsrExp[21] = 20'h00009;
        decA[0] = 10'd4;  decA[1] = 10'd8;  decA[2] = 10'd12; decA[3] = 10'd16;
        decB[0] = 10'd0;  decB[1] = 10'd0;  decB[2] = 10'd0;  decB[3] = 10'd3;

        rstn = 1'b0; enable = 1'b0; mode = 2'd0; dec_log2 = 3'd0;
        adc_a = '0; adc_b = '0; adc_valid = 1'b0;
        overflow_clr = 1'b0; fifo_full = 1'b0; fifo_afull = 1'b0;
        repeat (3) stepCycle();
        checkReset("por");
        rstn = 1'b1;
        stepCycle();

        // ADC pass-through, afull must not throttle it
        enable = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("activeHigh", 32'(active), 32'd1);
        fifo_afull = 1'b1;
        expectWord(20'hFFC01, cycCnt + 2);
        applyStimulus(10'h3FF, 10'h001, 1'b1);
        expectWord(20'h556AA, cycCnt + 2);
        applyStimulus(10'h155, 10'h2AA, 1'b1);
        expectWord(20'h801FF, cycCnt + 2);
        applyStimulus(10'h200, 10'h1FF, 1'b1);
        applyStimulus(10'h0, 10'h0, 1'b0);
        repeat (3) stepCycle();
        fifo_afull = 1'b0;
        checkOutput("drainPassThrough", 32'(sb.size()), 32'd0);

        // Decimate by 4; config changes while enabled must be ignored
        restart(2'd0, 3'd2);
        mode     = 2'd1;
        dec_log2 = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) expectWord(20'h02800, cycCnt + 2);
            applyStimulus(decA[i], decB[i], 1'b1);
            applyStimulus(10'h0, 10'h0, 1'b0);
        end
        repeat (3) stepCycle();
        checkOutput("drainDec4", 32'(sb.size()), 32'd0);

        // dec_log2=7 clamps to 16-sample averaging
        restart(2'd0, 3'd7);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expectWord(20'hFFC07, cycCnt + 2);
            applyStimulus(10'h3FF, 10'(i), 1'b1);
        end
        applyStimulus(10'h0, 10'h0, 1'b0);
        repeat (3) stepCycle();
        checkOutput("drainDecClamp", 32'(sb.size()), 32'd0);

        // Counter mode with afull toggling every 5 cycles
        restart(2'd1, 3'd0);
        patChk   = 1'b1;
        cntModel = '0;
        for (int i = 0; i < 30; i++) begin
            fifo_afull = ((i / 5) % 2) == 1;
            if (!fifo_afull) begin
                expectWord(cntModel, -1);
                cntModel = cntModel + 20'd1;
            end
            stepCycle();
        end
        enable     = 1'b0;
        fifo_afull = 1'b0;
        stepCycle();
        patChk = 1'b0;
        checkOutput("drainCounter", 32'(sb.size()), 32'd0);

        // LFSR mode, then restart after an enable low/high cycle
        restart(2'd2, 3'd0);
        for (int k = 1; k <= 21; k++) begin
            expectWord(lfsrExp[k], -1);
            stepCycle();
        end
        enable = 1'b0;
        stepCycle();
        stepCycle();
        enable = 1'b1;
        stepCycle();
        expectWord(20'h00001, -1);
        stepCycle();
        expectWord(20'h00002, -1);
        stepCycle();
        expectWord(20'h00004, -1);
        stepCycle();
        enable = 1'b0;
        stepCycle();
        checkOutput("drainLfsr", 32'(sb.size()), 32'd0);

        // Drops while full, then a drop coinciding with overflow_clr
        restart(2'd0, 3'd0);
        fifo_full = 1'b1;
        applyStimulus(10'h101, 10'h0F0, 1'b1);
        applyStimulus(10'h102, 10'h0F1, 1'b1);
        applyStimulus(10'h103, 10'h0F2, 1'b1);
        applyStimulus(10'h0, 10'h0, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("overflowAfter3", 32'(overflow), 32'd1);
        checkOutput("droppedAfter3", 32'(dropped_cnt), 32'd3);
        applyStimulus(10'h2AB, 10'h155, 1'b1);
        adc_valid = 1'b0;
        stepCycle();
        overflow_clr = 1'b1;
        stepCycle();
        overflow_clr = 1'b0;
        checkOutput("overflowDropWins", 32'(overflow), 32'd1);
        checkOutput("droppedDropWins", 32'(dropped_cnt), 32'd1);
        fifo_full = 1'b0;

        // Reset in the middle of a decimation window
        restart(2'd0, 3'd2);
        applyStimulus(10'd1, 10'd1, 1'b1);
        applyStimulus(10'd1, 10'd1, 1'b1);
        applyStimulus(10'h0, 10'h0, 1'b0);
        rstn = 1'b0;
        #1;
        checkReset("midDecim");
        stepCycle();
        stepCycle();
        rstn = 1'b1;
        stepCycle();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) expectWord(20'h00864, cycCnt + 2);
            applyStimulus(10'(i + 1), 10'd100, 1'b1);
        end
        applyStimulus(10'h0, 10'h0, 1'b0);
        repeat (3) stepCycle();
        checkOutput("drainAfterReset", 32'(sb.size()), 32'd0);

        // A lone overflow_clr clears both flag and counter
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(10'h3C0, 10'h00F, 1'b1);
        applyStimulus(10'h0, 10'h0, 1'b0);
        repeat (3) stepCycle();
        checkOutput("overflowSingleDrop", 32'(overflow), 32'd1);
        checkOutput("droppedSingleDrop", 32'(dropped_cnt), 32'd1);
        overflow_clr = 1'b1;
        stepCycle();
        overflow_clr = 1'b0;
        fifo_full    = 1'b0;
        checkOutput("overflowCleared", 32'(overflow), 32'd0);
        checkOutput("droppedCleared", 32'(dropped_cnt), 32'd0);

        repeat (2) stepCycle();
        checkOutput("drainFinal", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hsdaoh_sample_source.md
Name: hsdaoh_sample_source

Overview:
- Upstream producer for the HDMI output core, in the ADC clock domain.
- Turns paired 10-bit ADC samples, or internally generated test patterns, into 20-bit words on the write side of the async FIFO that the output core drains.
- Optional power-of-two boxcar decimation on the ADC path.
- Counts words dropped when the FIFO is full and reports a sticky overflow flag.

Parameters:
- CNT_W, 16, width of the dropped-word counter (saturating).
- MAX_DEC_LOG2, 4, largest decimation exponent supported; accumulator width is 10+MAX_DEC_LOG2 bits per channel.

Ports:
- clk_data  in  1  ADC/sample clock; the only clock of the block.
- rstn  in  1  asynchronous active-low reset.
- adc_a  in  10  channel A sample, offset binary.
- adc_b  in  10  channel B sample, offset binary.
- adc_valid  in  1  adc_a/adc_b valid this cycle.
- enable  in  1  streaming enable.
- mode  in  2  0=ADC, 1=counter, 2=LFSR, 3=idle.
- dec_log2  in  3  decimate by 2^dec_log2; values above MAX_DEC_LOG2 are clamped to MAX_DEC_LOG2.
- overflow_clr  in  1  single-cycle clear of overflow and dropped_cnt.
- fifo_full  in  1  FIFO write side full.
- fifo_afull  in  1  FIFO almost full (at least 4 free entries remain when low).
- fifo_write_en  out  1  write strobe.
- fifo_data  out  20  {chanA[9:0], chanB[9:0]}; the output core uses bits [19:12] and [9:2] in 8-bit mode and all bits in 10-bit mode.
- overflow  out  1  sticky: at least one word dropped.
- dropped_cnt  out  CNT_W  number of dropped words, saturating.
- active  out  1  high while the configuration is latched and streaming.

Behaviour:
- Reset values: fifo_write_en=0, fifo_data=0, overflow=0, dropped_cnt=0, active=0; accumulators, phase counter, pattern counter and LFSR are cleared; the LFSR is reset to 20'h00001.
- Configuration latch:
  - On the rising edge of enable, mode and dec_log2 are registered and active goes to 1 on the next cycle.
  - Changes to mode or dec_log2 while enable is high are ignored.
  - When enable falls, active goes to 0 next cycle and any partial decimation sum is discarded (no write).
  - Each rising edge of enable restarts the decimation phase at 0, the counter at 0 and the LFSR at 20'h00001.
- FSM states:
  - IDLE → RUN on the enable rising edge, provided latched mode≠3.
  - RUN → IDLE when enable=0.
  - With mode=3 the FSM stays in IDLE and active stays 0.
- ADC path (mode 0):
  - Stage 1 registers adc_a, adc_b and adc_valid.
  - Stage 2: per channel, the accumulator adds the sample whenever the valid bit is set. The phase counter runs 0..2^d−1. When phase=2^d−1, the output word is {sumA>>d, sumB>>d} (truncating), the accumulator reloads to 0 and the word is presented.
  - d=0 is a pass-through. Latency from adc_valid to fifo_write_en is exactly 2 cycles.
  - For d>0, the write occurs 2 cycles after the 2^d-th valid sample.
- Drop rule (ADC mode only):
  - If a word is ready and fifo_full=1 in that cycle, fifo_write_en stays 0, overflow is set, and dropped_cnt increments, saturating at all-ones.
  - fifo_afull is ignored in ADC mode.
- Counter mode (mode 1):
  - adc_valid is ignored. One word is written per cycle whenever fifo_afull=0.
  - fifo_data is a 20-bit counter starting at 0 that advances only on a write and wraps from 20'hFFFFF to 0.
  - The pattern has no gaps and nothing is dropped.
- LFSR mode (mode 2):
  - Same throttling as counter mode.
  - fifo_data is a Fibonacci LFSR, polynomial x^20+x^17+1. The new bit 0 is q[19]^q[16], shifted left. The LFSR advances only on a write.
  - The first word after enable is 20'h00001 and the second is 20'h00002.
- fifo_write_en is never asserted while fifo_full=1, in any mode.
- Overflow clear: overflow_clr=1 clears overflow and dropped_cnt. If a drop occurs in the same cycle, the drop wins: overflow=1 and dropped_cnt=1.
- Reset mid-operation: all state returns to reset values immediately, with no partial write. The FIFO is expected to be reset by the same rstn.

Decomposition:
- Shared package hsdaoh_pkg holds:
  - mode encodings MODE_ADC/MODE_CNT/MODE_LFSR/MODE_IDLE;
  - LFSR_SEED=20'h00001 and the tap positions;
  - SAMPLE_W=10 and WORD_W=20.
- One natural sub-module: hsdaoh_boxcar_decim, a per-channel accumulator with phase counter, instantiated twice and sharing the phase strobe.

Test Plan:
- Mode 0, d=0, adc_a=10'h3FF, adc_b=10'h001 with adc_valid at cycle N → fifo_write_en at N+2, fifo_data=20'hFFC01.
- Mode 0, d=2, samples A=4,8,12,16 and B=0,0,0,3 → exactly one write, fifo_data={10'd10, 10'd0}, 2 cycles after the 4th valid.
- Mode 1, fifo_afull toggled every 5 cycles → written words are 0,1,2,… with no gaps; fifo_write_en=0 whenever fifo_afull=1.
- Mode 2 → first three words are 20'h00001, 20'h00002, 20'h00004; word 21 is 20'h00009 (bit 16 fed back after 17 shifts); the sequence restarts at 20'h00001 after an enable low/high cycle.
- Mode 0, fifo_full held for 3 valid samples → 3 drops, overflow=1, dropped_cnt=3. overflow_clr pulsed in the same cycle as a 4th drop → dropped_cnt=1, overflow=1.
- rstn asserted mid-decimation (phase=2) → outputs at reset values. After release with enable high, the first write occurs after 2^d new valids.
